// File: rtl/readout_sequencer_if.sv
// Run-control, sample-valid, classifier and result handshake bundle for readout_sequencer.
interface readout_sequencer_if #(
    parameter int unsigned SHOT_W = 16
);
    logic              start;
    logic [SHOT_W-1:0] shot_num;
    logic              abort;
    logic              data_in;
    logic              cls_data_in;
    logic [1:0]        cls_state;
    logic              busy;
    logic              res_valid;
    logic              res_ready;
    logic [SHOT_W-1:0] n_ground;
    logic [SHOT_W-1:0] n_excited;
    logic [SHOT_W-1:0] n_line;
    logic [SHOT_W-1:0] n_shots;
    logic              timeout;

    modport master (
        output start, shot_num, abort, data_in, cls_state, res_ready,
        input  cls_data_in, busy, res_valid, n_ground, n_excited, n_line, n_shots, timeout
    );

    modport slave (
        input  start, shot_num, abort, data_in, cls_state, res_ready,
        output cls_data_in, busy, res_valid, n_ground, n_excited, n_line, n_shots, timeout
    );
endinterface

// File: rtl/readout_sequencer.sv
// Qubit readout sequencer: gates shot samples to a fixed-latency classifier and histograms results.
// Optional idle-input timeout is built when SEQ_TIMEOUT_EN is defined.
module readout_sequencer #(
    parameter int unsigned SHOT_W       = 16,
    parameter int unsigned CLASSIFY_LAT = 3,
    parameter int unsigned TIMEOUT_CYC  = 1000
) (
    input  logic                clk100,
    input  logic                rst_n,
    readout_sequencer_if.slave  bus
);
    localparam int unsigned LAT = CLASSIFY_LAT;

    if (CLASSIFY_LAT < 1 || CLASSIFY_LAT > 8) begin : g_bad_lat
        $error("CLASSIFY_LAT must be in 1..8");
    end
    if (TIMEOUT_CYC < 1) begin : g_bad_timeout
        $error("TIMEOUT_CYC must be at least 1");
    end

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_e;

    state_e            state_q, state_d;
    logic [SHOT_W-1:0] shot_q;
    logic [SHOT_W-1:0] n_ground_q, n_excited_q, n_line_q, n_shots_q;
    logic [LAT-1:0]    vld_q, vld_d;
    logic              busy_q, res_valid_q;
    logic              start_ok, take, tail, to_hit;

    assign start_ok        = bus.start && (bus.shot_num != '0);
    assign take            = bus.data_in && (state_q == RUN) && (n_shots_q < shot_q);
    assign tail            = vld_q[LAT-1];
    assign vld_d           = LAT'({vld_q, take});
    assign bus.cls_data_in = take;

`ifdef SEQ_TIMEOUT_EN
    localparam int unsigned TO_W = $clog2(TIMEOUT_CYC + 1);

    logic [TO_W-1:0] to_cnt_q;
    logic            timeout_q;

    // Fires on the TIMEOUT_CYC-th consecutive RUN cycle without an accepted sample.
    assign to_hit = (state_q == RUN) && !take && (to_cnt_q == TO_W'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk100 or negedge rst_n) begin
        if (!rst_n) begin
            to_cnt_q  <= '0;
            timeout_q <= 1'b0;
        end else if (bus.abort) begin
            to_cnt_q  <= '0;
        end else if (state_q == IDLE && start_ok) begin
            to_cnt_q  <= '0;
            timeout_q <= 1'b0;
        end else if (state_q == RUN) begin
            to_cnt_q <= take ? '0 : to_cnt_q + 1'b1;
            if (to_hit) timeout_q <= 1'b1;
        end
    end

    assign bus.timeout = timeout_q;
`else
    assign to_hit      = 1'b0;
    assign bus.timeout = 1'b0;
`endif

    // Next-state decode; abort overrides every other transition.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start_ok) state_d = RUN;
            RUN:     if (to_hit || n_shots_q == shot_q) state_d = DRAIN;
            DRAIN:   if (vld_q == '0) state_d = DONE;
            DONE:    if (res_valid_q && bus.res_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (bus.abort) state_d = IDLE;
    end

    always_ff @(posedge clk100 or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            shot_q      <= '0;
            n_ground_q  <= '0;
            n_excited_q <= '0;
            n_line_q    <= '0;
            n_shots_q   <= '0;
            vld_q       <= '0;
            busy_q      <= 1'b0;
            res_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            busy_q      <= (state_d == RUN) || (state_d == DRAIN);
            res_valid_q <= (state_d == DONE);
            vld_q       <= bus.abort ? '0 : vld_d;
            if (bus.abort) begin
                // Counts freeze; in-flight classifier results are discarded.
            end else if (state_q == IDLE && start_ok) begin
                shot_q      <= bus.shot_num;
                n_ground_q  <= '0;
                n_excited_q <= '0;
                n_line_q    <= '0;
                n_shots_q   <= '0;
            end else begin
                if (take) n_shots_q <= n_shots_q + 1'b1;
                if (tail) begin
                    case (bus.cls_state)
                        2'b01:   n_ground_q  <= n_ground_q + 1'b1;
                        2'b10:   n_excited_q <= n_excited_q + 1'b1;
                        default: n_line_q    <= n_line_q + 1'b1;
                    endcase
                end
            end
        end
    end

    assign bus.busy      = busy_q;
    assign bus.res_valid = res_valid_q;
    assign bus.n_ground  = n_ground_q;
    assign bus.n_excited = n_excited_q;
    assign bus.n_line    = n_line_q;
    assign bus.n_shots   = n_shots_q;
endmodule

// File: tb/tb_readout_sequencer.sv
// Self-checking bench for readout_sequencer: directed table, corner sequences, randomized runs.
module tb_readout_sequencer;
    localparam int unsigned SW  = 16;
    localparam int unsigned LAT = 3;
    localparam int unsigned TO  = 8;
`ifdef SEQ_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic clk100 = 1'b0;
    logic rst_n;
    always #5 clk100 = ~clk100;

    readout_sequencer_if #(.SHOT_W(SW)) bus_if ();

    readout_sequencer #(.SHOT_W(SW), .CLASSIFY_LAT(LAT), .TIMEOUT_CYC(TO)) dut (
        .clk100 (clk100),
        .rst_n  (rst_n),
        .bus    (bus_if.slave)
    );

    int n_pass = 0;
    int n_tot  = 0;

    // Reference model: run phase, quota, and histogram of classes handed to accepted shots.
    bit   m_idle, m_active, m_to;
    int   m_quota, m_taken, m_idlecnt;
    int   e_g, e_e, e_l;
    int   cls_cnt;
    logic       hist_v [LAT];
    logic [1:0] hist_c [LAT];
    logic [1:0] cls_q [$];

    typedef struct {
        int         shot;
        int         pulses;
        bit         gap;
        logic [7:0] cls;
        int         eg, ee, el, en;
    } vec_t;
    vec_t vecs [4];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    task automatic model_reset();
        m_idle = 1'b1; m_active = 1'b0; m_to = 1'b0;
        m_quota = 0; m_taken = 0; m_idlecnt = 0;
        e_g = 0; e_e = 0; e_l = 0;
    endtask

    // One clock: check the gated sample, play the classifier, advance model, then edge.
    task automatic step();
        bit         exp_cls, quota_met;
        logic [1:0] pick;
        #1;
        quota_met = (m_taken >= m_quota);
        exp_cls   = m_active && bus_if.data_in && !quota_met;
        chk("cls_data_in", 32'(bus_if.cls_data_in), 32'(exp_cls));
        if (bus_if.cls_data_in) cls_cnt++;
        bus_if.cls_state = hist_v[LAT-1] ? hist_c[LAT-1] : 2'($urandom);
        pick = (exp_cls && cls_q.size() > 0) ? cls_q.pop_front() : 2'($urandom);
        for (int i = LAT - 1; i > 0; i--) begin
            hist_v[i] = hist_v[i-1];
            hist_c[i] = hist_c[i-1];
        end
        hist_v[0] = bus_if.cls_data_in;
        hist_c[0] = pick;
        if (exp_cls) begin
            m_taken++;
            case (pick)
                2'b01:   e_g++;
                2'b10:   e_e++;
                default: e_l++;
            endcase
        end
        if (m_active) begin
            m_idlecnt = exp_cls ? 0 : m_idlecnt + 1;
            if (TO_EN && m_idlecnt == int'(TO)) begin
                m_active = 1'b0;
                m_to     = 1'b1;
            end else if (quota_met) begin
                m_active = 1'b0;
            end
        end
        if (bus_if.abort) begin
            m_idle = 1'b1; m_active = 1'b0;
        end else if (m_idle && bus_if.start && bus_if.shot_num != '0) begin
            m_idle = 1'b0; m_active = 1'b1; m_to = 1'b0;
            m_quota = int'(bus_if.shot_num); m_taken = 0; m_idlecnt = 0;
            e_g = 0; e_e = 0; e_l = 0;
        end
        @(posedge clk100);
        @(negedge clk100);
    endtask

    task automatic start_run(input int shot);
        bus_if.shot_num = SW'(shot);
        bus_if.start    = 1'b1;
        cls_cnt         = 0;
        step();
        bus_if.start = 1'b0;
        chk("busy_after_start", 32'(bus_if.busy), 32'd1);
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        bus_if.data_in = 1'b0;
        while (!bus_if.res_valid && n < 400) begin
            step();
            n++;
        end
        chk({tag, "_res_valid"}, 32'(bus_if.res_valid), 32'd1);
    endtask

    task automatic check_model(input string tag);
        chk({tag, "_n_ground"},  32'(bus_if.n_ground),  32'(e_g));
        chk({tag, "_n_excited"}, 32'(bus_if.n_excited), 32'(e_e));
        chk({tag, "_n_line"},    32'(bus_if.n_line),    32'(e_l));
        chk({tag, "_n_shots"},   32'(bus_if.n_shots),   32'(m_taken));
        chk({tag, "_timeout"},   32'(bus_if.timeout),   32'(m_to));
        chk({tag, "_busy"},      32'(bus_if.busy),      32'd0);
        chk({tag, "_sum"}, 32'(bus_if.n_ground) + 32'(bus_if.n_excited) + 32'(bus_if.n_line),
            32'(bus_if.n_shots));
    endtask

    task automatic release_result(input string tag);
        bus_if.res_ready = 1'b1;
        step();
        bus_if.res_ready = 1'b0;
        chk({tag, "_released_valid"}, 32'(bus_if.res_valid), 32'd0);
        chk({tag, "_released_busy"},  32'(bus_if.busy),      32'd0);
        m_idle = 1'b1;
    endtask

    initial begin
        logic [7:0] c;
        bit         aborted;
        int         shot;

        vecs[0] = '{4, 4, 1'b0, 8'b11_10_10_01, 1, 2, 1, 4};
        vecs[1] = '{2, 5, 1'b0, 8'b00_00_01_01, 2, 0, 0, 2};
        vecs[2] = '{3, 3, 1'b1, 8'b00_10_00_00, 0, 1, 2, 3};
        vecs[3] = '{1, 1, 1'b0, 8'b00_00_00_10, 0, 1, 0, 1};

        for (int i = 0; i < int'(LAT); i++) begin
            hist_v[i] = 1'b0;
            hist_c[i] = 2'b00;
        end
        model_reset();
        cls_cnt          = 0;
        rst_n            = 1'b0;
        bus_if.start     = 1'b0;
        bus_if.shot_num  = '0;
        bus_if.abort     = 1'b0;
        bus_if.data_in   = 1'b0;
        bus_if.cls_state = 2'b00;
        bus_if.res_ready = 1'b0;

        @(negedge clk100);
        chk("rst_busy",        32'(bus_if.busy),        32'd0);
        chk("rst_res_valid",   32'(bus_if.res_valid),   32'd0);
        chk("rst_timeout",     32'(bus_if.timeout),     32'd0);
        chk("rst_cls_data_in", 32'(bus_if.cls_data_in), 32'd0);
        chk("rst_n_shots",     32'(bus_if.n_shots),     32'd0);
        chk("rst_n_ground",    32'(bus_if.n_ground),    32'd0);
        rst_n = 1'b1;
        step();
        step();

        // Directed table of short runs
        for (int k = 0; k < 4; k++) begin
            cls_q.delete();
            c = vecs[k].cls;
            for (int j = 0; j < 4; j++) cls_q.push_back(c[2*j +: 2]);
            start_run(vecs[k].shot);
            for (int p = 0; p < vecs[k].pulses; p++) begin
                bus_if.data_in = 1'b1;
                step();
                if (vecs[k].gap) begin
                    bus_if.data_in = 1'b0;
                    step();
                end
            end
            wait_done($sformatf("vec%0d", k));
            chk($sformatf("vec%0d_tbl_ground", k),  32'(bus_if.n_ground),  32'(vecs[k].eg));
            chk($sformatf("vec%0d_tbl_excited", k), 32'(bus_if.n_excited), 32'(vecs[k].ee));
            chk($sformatf("vec%0d_tbl_line", k),    32'(bus_if.n_line),    32'(vecs[k].el));
            chk($sformatf("vec%0d_tbl_shots", k),   32'(bus_if.n_shots),   32'(vecs[k].en));
            chk($sformatf("vec%0d_cls_pulses", k),  32'(cls_cnt),          32'(vecs[k].en));
            check_model($sformatf("vec%0d", k));
            if (k == 0) begin
                for (int s = 0; s < 10; s++) begin
                    step();
                    chk("stall_res_valid", 32'(bus_if.res_valid), 32'd1);
                    chk("stall_n_excited", 32'(bus_if.n_excited), 32'(vecs[0].ee));
                    chk("stall_n_shots",   32'(bus_if.n_shots),   32'(vecs[0].en));
                end
            end
            release_result($sformatf("vec%0d", k));
            chk($sformatf("vec%0d_retained", k), 32'(bus_if.n_shots), 32'(vecs[k].en));
        end

        // Abort one cycle after the 2nd of 3 shots; nothing has left the classifier yet
        start_run(3);
        bus_if.data_in = 1'b1;
        step();
        step();
        bus_if.data_in = 1'b0;
        bus_if.abort   = 1'b1;
        step();
        bus_if.abort = 1'b0;
        chk("abort_busy",    32'(bus_if.busy),    32'd0);
        chk("abort_n_shots", 32'(bus_if.n_shots), 32'd2);
        for (int s = 0; s < int'(LAT) + 4; s++) begin
            bus_if.data_in = s[0];
            step();
            chk("abort_res_valid", 32'(bus_if.res_valid), 32'd0);
            chk("abort_late_counts",
                32'(bus_if.n_ground) + 32'(bus_if.n_excited) + 32'(bus_if.n_line), 32'd0);
        end

        // start with zero shots is ignored
        bus_if.shot_num = '0;
        bus_if.start    = 1'b1;
        step();
        bus_if.start   = 1'b0;
        chk("zero_shot_busy", 32'(bus_if.busy), 32'd0);
        bus_if.data_in = 1'b1;
        step();
        step();
        chk("zero_shot_busy_later", 32'(bus_if.busy),      32'd0);
        chk("zero_shot_res_valid",  32'(bus_if.res_valid), 32'd0);
        bus_if.data_in = 1'b0;

        // Idle-input timeout: 5 shots requested, only 2 delivered
        start_run(5);
        bus_if.data_in = 1'b1;
        step();
        step();
        bus_if.data_in = 1'b0;
        if (TO_EN) begin
            wait_done("timeout");
            chk("timeout_flag",    32'(bus_if.timeout), 32'd1);
            chk("timeout_n_shots", 32'(bus_if.n_shots), 32'd2);
            check_model("timeout");
            release_result("timeout");
        end else begin
            for (int s = 0; s < 30; s++) step();
            chk("no_timeout_busy",      32'(bus_if.busy),      32'd1);
            chk("no_timeout_res_valid", 32'(bus_if.res_valid), 32'd0);
            chk("no_timeout_flag",      32'(bus_if.timeout),   32'd0);
            bus_if.abort = 1'b1;
            step();
            bus_if.abort = 1'b0;
            chk("no_timeout_abort_busy", 32'(bus_if.busy), 32'd0);
        end

        // Reset in the middle of a run, then stray samples
        start_run(6);
        bus_if.data_in = 1'b1;
        step();
        step();
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_busy",    32'(bus_if.busy),        32'd0);
        chk("midrst_n_shots", 32'(bus_if.n_shots),     32'd0);
        chk("midrst_cls",     32'(bus_if.cls_data_in), 32'd0);
        model_reset();
        @(negedge clk100);
        rst_n = 1'b1;
        for (int s = 0; s < int'(LAT) + 3; s++) step();
        chk("midrst_counts",
            32'(bus_if.n_ground) + 32'(bus_if.n_excited) + 32'(bus_if.n_line) + 32'(bus_if.n_shots),
            32'd0);
        bus_if.data_in = 1'b0;

        // Randomized runs with stray starts, random stalls and occasional aborts
        for (int r = 0; r < 25; r++) begin
            cls_q.delete();
            shot = $urandom_range(1, 12);
            start_run(shot);
            aborted = 1'b0;
            for (int n = 0; n < 300 && m_active; n++) begin
                bus_if.data_in  = ($urandom_range(0, 3) != 0);
                bus_if.start    = ($urandom_range(0, 7) == 0);
                bus_if.shot_num = SW'($urandom_range(0, 20));
                bus_if.abort    = ($urandom_range(0, 79) == 0);
                step();
                if (bus_if.abort) begin
                    bus_if.abort = 1'b0;
                    aborted      = 1'b1;
                    chk("rnd_abort_busy",      32'(bus_if.busy),      32'd0);
                    chk("rnd_abort_res_valid", 32'(bus_if.res_valid), 32'd0);
                    break;
                end
            end
            bus_if.start   = 1'b0;
            bus_if.data_in = 1'b0;
            if (!aborted) begin
                wait_done($sformatf("rnd%0d", r));
                check_model($sformatf("rnd%0d", r));
                for (int s = $urandom_range(0, 3); s > 0; s--) begin
                    step();
                    chk("rnd_stall_res_valid", 32'(bus_if.res_valid), 32'd1);
                end
                release_result($sformatf("rnd%0d", r));
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end
endmodule

// File: doc/readout_sequencer.md
READOUT_SEQUENCER -- requirements
Module: readout_sequencer

Interface
REQ-001 SHALL have parameter SHOT_W, default 16, width of shot count and all result counters.
REQ-002 SHALL have parameter CLASSIFY_LAT, default 3, fixed classifier latency in cycles from cls_data_in to cls_state; legal range 1..8.
REQ-003 SHALL have parameter TIMEOUT_CYC, default 1000, idle-input timeout in cycles; used only when SEQ_TIMEOUT_EN is defined.
REQ-004 SHALL have port clk100, input, 1, single clock; all logic on its rising edge.
REQ-005 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port start, input, 1, begin a run; sampled only in IDLE.
REQ-007 SHALL have port shot_num, input, SHOT_W, shots per run; captured on an accepted start.
REQ-008 SHALL have port abort, input, 1, cancel the run from any state.
REQ-009 SHALL have port data_in, input, 1, new i/q sample present this cycle.
REQ-010 SHALL have port cls_data_in, output, 1, sample-valid forwarded to the classifier.
REQ-011 SHALL have port cls_state, input, 2, classifier result: 01 ground, 10 excited, 11 on line.
REQ-012 SHALL have port busy, output, 1, high in RUN and DRAIN.
REQ-013 SHALL have ports res_valid (output, 1) and res_ready (input, 1), result handshake.
REQ-014 SHALL have ports n_ground, n_excited, n_line, n_shots, each output, SHOT_W, run counts.
REQ-015 SHALL have port timeout, output, 1, the run ended by timeout.

Function
REQ-016 SHALL implement FSM states IDLE, RUN, DRAIN, DONE.
REQ-017 IDLE: start=1 with shot_num!=0 SHALL capture shot_num, clear all counters and timeout, and enter RUN next cycle; start with shot_num=0 SHALL be ignored.
REQ-018 RUN: cls_data_in SHALL be combinational data_in AND state==RUN AND n_shots<captured shot_num; n_shots SHALL increment on each such cycle.
REQ-019 RUN SHALL go to DRAIN on the cycle after n_shots reaches the captured shot_num.
REQ-020 The block SHALL track in-flight samples with a CLASSIFY_LAT-deep valid shift register loaded from cls_data_in, which advances every cycle.
REQ-021 When the shift-register tail is 1, the block SHALL sample cls_state: 01 increments n_ground, 10 increments n_excited, 11 or 00 increments n_line.
REQ-022 DRAIN SHALL go to DONE on the first cycle the shift register is all zero, so that n_ground+n_excited+n_line==n_shots in DONE.
REQ-023 DONE: res_valid SHALL be 1 with all counts held stable; res_valid&&res_ready SHALL return the FSM to IDLE, with counts retained until the next accepted start.
REQ-024 data_in outside RUN, or after the shot quota is met, SHALL be dropped (cls_data_in=0).
REQ-025 abort SHALL force IDLE on the next edge from any state, clear the shift register, deassert res_valid, and have priority over all other transitions.
REQ-026 busy SHALL be a registered decode of state; res_valid SHALL be registered.
REQ-027 Counters SHALL NOT overflow, because each is bounded by shot_num <= 2^SHOT_W-1.

Reset
REQ-028 rst_n low SHALL asynchronously set state=IDLE and clear the shift register, all counters, busy, res_valid, timeout and cls_data_in.
REQ-029 Reset deassertion mid-stream SHALL NOT cause any count or cls_data_in pulse until a new start is accepted.

Configuration
REQ-030 When macro SEQ_TIMEOUT_EN is defined, a counter SHALL clear on each accepted sample and increment each RUN cycle without one; on reaching TIMEOUT_CYC the block SHALL set timeout=1 and go to DRAIN.
REQ-031 When SEQ_TIMEOUT_EN is undefined, the timeout port SHALL be tied 0, no timeout counter is built, and RUN SHALL wait indefinitely.

Verification
REQ-032 shot_num=4; 4 data_in pulses with cls_state 01,10,10,11 -> DONE with n_ground=1, n_excited=2, n_line=1, n_shots=4, res_valid=1.
REQ-033 shot_num=2; data_in held high for 5 cycles -> exactly 2 cls_data_in pulses, n_shots=2.
REQ-034 DONE with res_ready=0 for 10 cycles -> res_valid and counts stable; res_ready=1 -> IDLE next cycle.
REQ-035 abort one cycle after the 2nd of 3 shots -> IDLE, busy=0, res_valid never asserts; late classifier outputs are not counted.
REQ-036 SEQ_TIMEOUT_EN, TIMEOUT_CYC=8, shot_num=5, only 2 samples -> timeout=1 and DONE with n_shots=2; without the macro -> remains in RUN.
REQ-037 start with shot_num=0 -> state stays IDLE, busy=0.
